// File: rtl/cache_pkg.sv
// Shared cache refill definitions: default geometry
// and the line-fill state encoding.
package cache_pkg;

  localparam int C_ADDR_W = 32;
  localparam int C_DATA_W = 32;
  localparam int C_WORDS  = 8;
  localparam int C_OFS_W  = $clog2(C_WORDS);
  localparam int C_BYTE_W = $clog2(C_DATA_W / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } fill_state_t;

endpackage

// File: rtl/fill_word_counter.sv
// Wrapping word pointer plus words-remaining counter
// for one line fill; last flags the final beat.
module fill_word_counter
  import cache_pkg::*;
#(
  parameter int WORDS  = C_WORDS,
  parameter int OFS_W  = $clog2(WORDS),
  parameter int LEFT_W = $clog2(WORDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_load,
  input  logic [OFS_W-1:0]  i_load_ofs,
  input  logic              i_inc,
  output logic [OFS_W-1:0]  o_ptr,
  output logic [LEFT_W-1:0] o_left,
  output logic              o_last
);

  logic [OFS_W-1:0]  r_ptr;
  logic [LEFT_W-1:0] r_left;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr  <= '0;
      r_left <= '0;
    end else if (i_en) begin
      if (i_load) begin
        r_ptr  <= i_load_ofs;
        r_left <= LEFT_W'(WORDS);
      end else if (i_inc) begin
        // Power-of-two line: the pointer wraps naturally
        r_ptr  <= r_ptr + 1'b1;
        r_left <= r_left - 1'b1;
      end
    end
  end

  assign o_ptr  = r_ptr;
  assign o_left = r_left;
  assign o_last = (r_left == LEFT_W'(1));

endmodule

// File: rtl/line_fill_sequencer.sv
// Cache line refill engine: one critical-word-first
// burst per miss, streamed into the data array.
module line_fill_sequencer
  import cache_pkg::*;
#(
  parameter int ADDR_W         = C_ADDR_W,
  parameter int DATA_W         = C_DATA_W,
  parameter int WORDS_PER_LINE = C_WORDS,
  parameter int OFS_W          = $clog2(WORDS_PER_LINE),
  parameter int BYTE_W         = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              array_we,
  output logic [OFS_W-1:0]  array_ofs,
  output logic [DATA_W-1:0] array_wdata,
  output logic              crit_valid,
  output logic              fill_done,
  output logic              busy,
  output logic              err_spurious
);

  localparam int LEFT_W = $clog2(WORDS_PER_LINE + 1);
  localparam int LINE_B = OFS_W + BYTE_W;
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << LINE_B) - ADDR_W'(1));

  fill_state_t       r_state;
  fill_state_t       w_next;
  logic [ADDR_W-1:0] r_line_base;
  logic [OFS_W-1:0]  r_crit_ofs;
  logic              r_err;

  logic              w_accept;
  logic              w_beat;
  logic              w_spur;
  logic [OFS_W-1:0]  w_ptr;
  logic [LEFT_W-1:0] w_left;
  logic              w_last;
  logic [OFS_W-1:0]  w_miss_ofs;

  assign w_miss_ofs = miss_addr[LINE_B-1:BYTE_W];

  fill_word_counter #(
    .WORDS  (WORDS_PER_LINE),
    .OFS_W  (OFS_W),
    .LEFT_W (LEFT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_en       (enable),
    .i_load     (w_accept),
    .i_load_ofs (w_miss_ofs),
    .i_inc      (w_beat),
    .o_ptr      (w_ptr),
    .o_left     (w_left),
    .o_last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_line_base <= '0;
      r_crit_ofs  <= '0;
      r_err       <= 1'b0;
    end else if (enable) begin
      r_state <= w_next;
      if (w_accept) begin
        r_line_base <= miss_addr & LINE_MASK;
        r_crit_ofs  <= w_miss_ofs;
      end
      if (w_spur) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    w_accept      = 1'b0;
    w_beat        = 1'b0;
    w_spur        = 1'b0;
    fill_done     = 1'b0;
    crit_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        miss_ready = enable;
        w_spur     = enable & mem_rsp_valid;
        if (enable && miss_valid) begin
          w_accept = 1'b1;
          w_next   = REQ;
        end
      end
      REQ: begin
        mem_req_valid = enable;
        w_spur        = enable & mem_rsp_valid;
        if (mem_req_ready) w_next = FILL;
      end
      FILL: begin
        w_beat = enable & mem_rsp_valid;
        crit_valid = w_beat &&
          (w_left == LEFT_W'(WORDS_PER_LINE));
        if (w_beat && w_last) w_next = DONE;
      end
      DONE: begin
        fill_done = enable;
        w_spur    = enable & mem_rsp_valid;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign mem_req_addr = r_line_base |
    (ADDR_W'(r_crit_ofs) << BYTE_W);
  assign array_we     = w_beat;
  assign array_ofs    = w_ptr;
  assign array_wdata  = mem_rsp_data;
  assign busy         = (r_state != IDLE);
  assign err_spurious = r_err;

endmodule

// File: tb/tb_line_fill_sequencer.sv
// Directed bench for line_fill_sequencer with a
// behavioural refill model checked every cycle.
module tb_line_fill_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        miss_valid = 1'b0;
  logic        miss_ready;
  logic [31:0] miss_addr = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        array_we;
  logic [2:0]  array_ofs;
  logic [31:0] array_wdata;
  logic        crit_valid;
  logic        fill_done;
  logic        busy;
  logic        err_spurious;

  line_fill_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .miss_valid    (miss_valid),
    .miss_ready    (miss_ready),
    .miss_addr     (miss_addr),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .array_we      (array_we),
    .array_ofs     (array_ofs),
    .array_wdata   (array_wdata),
    .crit_valid    (crit_valid),
    .fill_done     (fill_done),
    .busy          (busy),
    .err_spurious  (err_spurious)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 request, 2 fill, 3 done
  int          m_ph = 0;
  int          m_k = 0;
  logic [31:0] m_base = '0;
  int          m_crit = 0;
  logic        m_err = 1'b0;
  int          cyc = 0;
  bit          started = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_ph  <= 0;
      m_k   <= 0;
      m_err <= 1'b0;
    end else if (enable) begin
      if (mem_rsp_valid && m_ph != 2) m_err <= 1'b1;
      case (m_ph)
        0: if (miss_valid) begin
          m_base <= {miss_addr[31:5], 5'd0};
          m_crit <= int'(miss_addr[4:2]);
          m_k    <= 0;
          m_ph   <= 1;
        end
        1: if (mem_req_ready) m_ph <= 2;
        2: if (mem_rsp_valid) begin
          m_k <= m_k + 1;
          if (m_k == 7) m_ph <= 3;
        end
        default: m_ph <= 0;
      endcase
    end
  end

  int          log_ofs[$];
  int          crit_log[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          acc_cyc = 0;
  int          reqv_cnt = 0;
  logic [31:0] last_req = '0;

  always @(negedge clk) begin
    if (started) begin
      bit e_we;
      e_we = enable && m_ph == 2 && mem_rsp_valid;
      chk("busy", busy, m_ph != 0);
      chk("miss_ready", miss_ready,
          enable && m_ph == 0);
      chk("req_valid", mem_req_valid,
          enable && m_ph == 1);
      chk("array_we", array_we, e_we);
      chk("crit_valid", crit_valid,
          e_we && m_k == 0);
      chk("fill_done", fill_done,
          enable && m_ph == 3);
      chk("err", err_spurious, m_err);
      if (enable && m_ph == 1)
        chk("req_addr", mem_req_addr,
            m_base + 32'(m_crit * 4));
      if (e_we) begin
        chk("ofs", array_ofs, (m_crit + m_k) % 8);
        chk("wdata", array_wdata, mem_rsp_data);
      end
      if (array_we) log_ofs.push_back(int'(array_ofs));
      if (crit_valid) crit_log.push_back(int'(array_ofs));
      if (fill_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (miss_valid && miss_ready) acc_cyc = cyc;
      if (mem_req_valid) begin
        reqv_cnt++;
        last_req = mem_req_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_ofs.delete();
    crit_log.delete();
    reqv_cnt = 0;
  endtask

  task automatic wait_done(input int start);
    for (int i = 0; i < 12 && done_cnt == start; i++)
      tick();
    chk("done_seen", done_cnt - start, 1);
  endtask

  // Memory returns the first beat one cycle after
  // accepting the request
  task automatic start_fill(input logic [31:0] a,
                            input int stall);
    clear_logs();
    miss_valid = 1'b1;
    miss_addr  = a;
    tick();
    miss_valid = 1'b0;
    repeat (stall) tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
  endtask

  task automatic beats(input logic [31:0] a,
                       input int first, input int last,
                       input int gap, input int en_at);
    for (int i = first; i <= last; i++) begin
      if (i == en_at) begin
        enable = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = {a[15:0], 16'(i)};
      tick();
      mem_rsp_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic run_fill(input logic [31:0] a,
                          input int stall, input int gap,
                          input int en_at);
    int d0;
    d0 = done_cnt;
    start_fill(a, stall);
    beats(a, 0, 7, gap, en_at);
    wait_done(d0);
  endtask

  task automatic chk_seq(input string nm,
                         input int e[8]);
    chk({nm, "_n"}, log_ofs.size(), 8);
    for (int i = 0; i < 8 && i < log_ofs.size(); i++)
      chk(nm, log_ofs[i], e[i]);
  endtask

  initial begin
    int e[8];
    int d0;
    tick();
    started = 1;
    tick();
    chk("rst_miss_ready", miss_ready, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // Aligned fill
    run_fill(32'h0000_1000, 0, 0, -1);
    chk("t1_req_addr", last_req, 32'h1000);
    e = '{0, 1, 2, 3, 4, 5, 6, 7};
    chk_seq("t1_ofs", e);
    chk("t1_crit_n", crit_log.size(), 1);
    chk("t1_crit_ofs", crit_log[0], 0);
    chk("t1_latency", done_cyc - acc_cyc + 1, 12);
    tick();

    // Critical word wrap
    run_fill(32'h0000_101C, 0, 0, -1);
    chk("t2_req_addr", last_req, 32'h101C);
    e = '{7, 0, 1, 2, 3, 4, 5, 6};
    chk_seq("t2_ofs", e);
    chk("t2_crit_n", crit_log.size(), 1);
    chk("t2_crit_ofs", crit_log[0], 7);
    tick();

    // Request stall and beat gaps
    run_fill(32'h0000_5014, 3, 2, -1);
    chk("t3_reqv_cycles", reqv_cnt, 4);
    chk("t3_req_addr", last_req, 32'h5014);
    e = '{5, 6, 7, 0, 1, 2, 3, 4};
    chk_seq("t3_ofs", e);
    tick();

    // Enable low mid-fill
    run_fill(32'h0000_3004, 0, 0, 3);
    e = '{1, 2, 3, 4, 5, 6, 7, 0};
    chk_seq("t4_ofs", e);
    tick();

    // Reset after the third beat
    d0 = done_cnt;
    start_fill(32'h0000_4000, 0);
    beats(32'h4000, 0, 2, 0, -1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_miss_ready", miss_ready, 1);
    tick();
    tick();
    chk("t5_no_done", done_cnt, d0);
    run_fill(32'h0000_2008, 0, 0, -1);
    e = '{2, 3, 4, 5, 6, 7, 0, 1};
    chk_seq("t5_ofs", e);
    tick();

    // Spurious beat while idle
    clear_logs();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBAD0_0000;
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("t6_err", err_spurious, 1);
    chk("t6_no_we", log_ofs.size(), 0);
    tick();
    run_fill(32'h0000_6000, 0, 0, -1);
    chk("t6_err_sticky", err_spurious, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_err_clr", err_spurious, 0);
    tick();

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/line_fill_sequencer.md
Name: line_fill_sequencer

Overview:
- Cache refill engine between the miss handler and the external memory port of the set-associative cache.
- Accepts one line-miss request and issues a single burst read to memory, critical word first.
- Streams the returned words into the data array at wrapping word offsets and flags the critical word and fill completion.
- Counts words upward with wrap; it is the producer side of the per-line down-counters used by the cache.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width; must be a power of 2, at least 8.
- WORDS_PER_LINE, 8, words per cache line; must be a power of 2, at least 2.
- OFS_W, $clog2(WORDS_PER_LINE), word-offset width (3 by default).
- BYTE_W, $clog2(DATA_W/8), byte-in-word offset width (2 by default).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, reset, synchronous, active-high.
- enable, input, 1, global advance enable; when low, all state is frozen.
- miss_valid, input, 1, miss request present.
- miss_ready, output, 1, sequencer can accept a miss.
- miss_addr, input, ADDR_W, byte address of the missing access.
- mem_req_valid, output, 1, burst read request.
- mem_req_ready, input, 1, memory accepts the request.
- mem_req_addr, output, ADDR_W, address of the first (critical) word.
- mem_rsp_valid, input, 1, one data beat present.
- mem_rsp_data, input, DATA_W, beat data.
- array_we, output, 1, data-array word write strobe.
- array_ofs, output, OFS_W, word offset within the line being written.
- array_wdata, output, DATA_W, word to write.
- crit_valid, output, 1, current beat is the requested word.
- fill_done, output, 1, one-cycle pulse when the line is complete.
- busy, output, 1, sequencer is not in IDLE.
- err_spurious, output, 1, sticky flag: a beat arrived outside FILL.

Behaviour:
- Reset, which takes priority over enable:
  - state=IDLE; word_ptr=0; words_left=0; line_base=0; crit_ofs=0.
  - err_spurious=0.
  - All outputs 0 except miss_ready=1.
- enable=0:
  - No state or register update.
  - array_we, fill_done and crit_valid are forced to 0.
  - miss_ready=0 and mem_req_valid=0, so no handshake can complete.
- States: IDLE, REQ, FILL, DONE.
- IDLE: miss_ready=1. On miss_valid&&miss_ready:
  - line_base = miss_addr with the low OFS_W+BYTE_W bits cleared.
  - crit_ofs = miss_addr[OFS_W+BYTE_W-1:BYTE_W].
  - word_ptr = crit_ofs; words_left = WORDS_PER_LINE; go to REQ.
- REQ:
  - mem_req_valid=1.
  - mem_req_addr = line_base | (crit_ofs << BYTE_W).
  - Hold until mem_req_ready, then go to FILL. The request must be accepted before beats count; the memory returns beats in wrapping order.
- FILL, on each cycle with mem_rsp_valid:
  - Combinational, same cycle: array_we=1; array_ofs=word_ptr; array_wdata=mem_rsp_data; crit_valid=1 only when words_left==WORDS_PER_LINE.
  - Registered: word_ptr = (word_ptr+1) mod WORDS_PER_LINE, a natural OFS_W wrap (7 wraps to 0); words_left decrements.
  - When words_left==1 on a beat, go to DONE.
  - Cycles without mem_rsp_valid: no write, counters hold.
- DONE: fill_done=1 for exactly one enabled cycle; miss_ready=0; next state IDLE.
- Latency: miss accepted to fill_done is at least 1 + 1 + WORDS_PER_LINE + 1 cycles with zero memory stalls. A new miss is accepted on the cycle after DONE.
- mem_rsp_valid in IDLE, REQ or DONE: the beat is ignored (no write) and err_spurious is set; only reset clears it.
- Reset mid-fill: return to IDLE immediately with no fill_done. The partially written line is the tag logic's responsibility (it stays invalid).
- A miss is never accepted while busy=1.

Decomposition:
- Shared package cache_pkg holds:
  - WORDS_PER_LINE, DATA_W, ADDR_W defaults.
  - Derived OFS_W and BYTE_W.
  - State encoding constants: IDLE=2'd0, REQ=2'd1, FILL=2'd2, DONE=2'd3.
- One sub-module, fill_word_counter:
  - OFS_W-bit wrap counter with load, increment and enable.
  - Paired words-remaining counter with a terminal flag (last).
  - Instantiated once.
- FSM and output decode stay in the top level.

Test Plan:
- Basic aligned fill: miss_addr=0x0000_1000, mem_req_ready=1, 8 back-to-back beats D0..D7.
  - mem_req_addr=0x1000.
  - Writes at offsets 0..7; crit_valid on offset 0 only.
  - fill_done exactly 12 cycles after miss acceptance.
- Critical word wrap: miss_addr=0x0000_101C.
  - mem_req_addr=0x101C.
  - Offsets written in order 7,0,1,...,6; crit_valid on the offset-7 beat only.
- Stalls:
  - mem_req_ready held low 3 cycles: mem_req_valid and mem_req_addr stay stable.
  - mem_rsp_valid gaps of 2 cycles between beats: no extra writes; fill_done after the 8th beat only.
- enable low for 4 cycles mid-FILL while mem_rsp_valid=0: word_ptr and words_left unchanged; the fill completes normally after enable returns.
- Reset after the 3rd beat: next cycle busy=0, miss_ready=1, no fill_done. A new miss at 0x2008 then fills offsets 2..7,0,1.
- Spurious beat: mem_rsp_valid=1 while IDLE → no array_we; err_spurious=1 and remains 1 until reset.
